core_s1_fetch: RTL and testbench



---
 rtl/letc_pkg.sv | 10 +
 rtl/core_s1_fetch.sv | 139 +++++++++++++
 tb/tb_core_s1_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/letc_pkg.sv
// Shared LETC core types and constants.
// Stage 1 uses word_t, the PC step and the default reset vector from here.
package letc_pkg;

  typedef logic [31:0] word_t;

  localparam word_t PC_INCREMENT     = 32'd4;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/core_s1_fetch.sv
// LETC core Stage 1 instruction fetcher: owns the PC, keeps one L1I request in flight and
// holds each fetched word for Stage 2 until it is accepted, redirected or halted.
module core_s1_fetch
  import letc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,

  output logic        icache_req_valid,
  input  logic        icache_req_ready,
  output logic [31:0] icache_req_addr,
  input  logic        icache_rsp_valid,
  input  logic [31:0] icache_rsp_data,
  input  logic        icache_rsp_fault,

  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_fault,

  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted
);

  typedef enum logic [2:0] {
    StInit,
    StRequest,
    StWaitRsp,
    StPresent,
    StHalt
  } fetch_state_e;

  fetch_state_e state_q;
  word_t        pc_q;
  word_t        instruction_q;
  word_t        instr_pc_q;
  logic         instr_fault_q;
  logic         discard_q;

  word_t redirect_target;
  assign redirect_target = redirect_pc & ~word_t'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StInit;
      pc_q          <= RESET_PC;
      instruction_q <= '0;
      instr_pc_q    <= '0;
      instr_fault_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          if (halt_req) begin
            state_q <= StHalt;
          end else begin
            if (redirect_valid) pc_q <= redirect_target;
            state_q <= StRequest;
          end
        end

        StRequest: begin
          if (halt_req) begin
            state_q <= StHalt;
          end else if (redirect_valid) begin
            pc_q <= redirect_target;
            // A request already handed to the L1I returns stale data; drop it on arrival.
            if (icache_req_ready) begin
              discard_q <= 1'b1;
              state_q   <= StWaitRsp;
            end
          end else if (icache_req_ready) begin
            state_q <= StWaitRsp;
          end
        end

        StWaitRsp: begin
          if (halt_req) begin
            state_q <= StHalt;
          end else if (redirect_valid) begin
            pc_q <= redirect_target;
            if (icache_rsp_valid) begin
              discard_q <= 1'b0;
              state_q   <= StRequest;
            end else begin
              discard_q <= 1'b1;
            end
          end else if (icache_rsp_valid) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              state_q   <= StRequest;
            end else begin
              instruction_q <= icache_rsp_data;
              instr_fault_q <= icache_rsp_fault;
              instr_pc_q    <= pc_q;
              state_q       <= StPresent;
            end
          end
        end

        StPresent: begin
          if (halt_req) begin
            state_q <= StHalt;
          end else if (redirect_valid) begin
            pc_q    <= redirect_target;
            state_q <= StRequest;
          end else if (instr_ready) begin
            pc_q    <= pc_q + PC_INCREMENT;
            state_q <= StRequest;
          end
        end

        StHalt: state_q <= StHalt;

        default: state_q <= StInit;
      endcase
    end
  end

  assign icache_req_valid = (state_q == StRequest);
  assign icache_req_addr  = pc_q;
  assign instr_valid      = (state_q == StPresent);
  assign instruction      = instruction_q;
  assign instr_pc         = instr_pc_q;
  assign instr_fault      = instr_fault_q;
  assign halted           = (state_q == StHalt);

  // The L1I may only answer the single outstanding request; HALT tolerates late answers.
  rsp_only_when_waiting_a : assert property (
    @(posedge clk) disable iff (!rst_n)
    icache_rsp_valid |-> (state_q == StWaitRsp || state_q == StHalt)
  );

endmodule

// File: tb/tb_core_s1_fetch.sv
// Directed bench for core_s1_fetch: a one-outstanding L1I responder plus a cycle-exact
// Stage 2 script; outputs are sampled on the falling edge.
module tb_core_s1_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [31:0] icache_req_addr;
  logic        icache_rsp_valid;
  logic [31:0] icache_rsp_data;
  logic        icache_rsp_fault;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;

  int          n_total = 0;
  int          n_pass  = 0;
  int          rsp_lat = 1;
  logic [31:0] rsp_word  = 32'h0000_0013;
  logic [31:0] fault_addr = 32'h0000_0001;

  core_s1_fetch #(
    .RESET_PC(32'h8000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .icache_req_valid (icache_req_valid),
    .icache_req_ready (icache_req_ready),
    .icache_req_addr  (icache_req_addr),
    .icache_rsp_valid (icache_rsp_valid),
    .icache_rsp_data  (icache_rsp_data),
    .icache_rsp_fault (icache_rsp_fault),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instruction      (instruction),
    .instr_pc         (instr_pc),
    .instr_fault      (instr_fault),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt_req         (halt_req),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // L1I model: sees the handshake just after the falling edge, answers rsp_lat edges later.
  initial begin : l1i
    logic [31:0] addr;
    icache_rsp_valid = 1'b0;
    icache_rsp_data  = '0;
    icache_rsp_fault = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && icache_req_valid && icache_req_ready) begin
        addr = icache_req_addr;
        repeat (rsp_lat) @(posedge clk);
        #1;
        icache_rsp_valid = 1'b1;
        icache_rsp_data  = rsp_word;
        icache_rsp_fault = (addr == fault_addr);
        @(posedge clk);
        #1;
        icache_rsp_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : script
    rst_n            = 1'b0;
    icache_req_ready = 1'b1;
    instr_ready      = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    halt_req         = 1'b0;
    repeat (3) step();

    check("rst_req_valid",   icache_req_valid, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_halted",      halted, 0);
    check("rst_instruction", instruction, 0);
    check("rst_instr_pc",    instr_pc, 0);
    check("rst_instr_fault", instr_fault, 0);
    rst_n = 1'b1;

    // INIT then REQUEST to the reset vector
    step();
    check("first_req_valid", icache_req_valid, 1);
    check("first_req_addr",  icache_req_addr, 32'h8000_0000);
    step();
    check("wait_no_req",     icache_req_valid, 0);
    check("wait_no_instr",   instr_valid, 0);
    step();
    check("first_instr_valid", instr_valid, 1);
    check("first_instruction", instruction, 32'h0000_0013);
    check("first_instr_pc",    instr_pc, 32'h8000_0000);
    check("first_instr_fault", instr_fault, 0);

    // Stage 2 stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      check("stall_instr_valid", instr_valid, 1);
      check("stall_instr_pc",    instr_pc, 32'h8000_0000);
      check("stall_instruction", instruction, 32'h0000_0013);
      check("stall_no_req",      icache_req_valid, 0);
      if (i < 4) step();
    end
    instr_ready = 1'b1;
    rsp_lat     = 2;
    step();
    instr_ready = 1'b0;
    check("next_req_valid", icache_req_valid, 1);
    check("next_req_addr",  icache_req_addr, 32'h8000_0004);
    check("next_no_instr",  instr_valid, 0);

    // Redirect while waiting: the old response must be dropped
    step();
    check("rdw_waiting", icache_req_valid, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1002;
    step();
    redirect_valid = 1'b0;
    check("rdw_no_instr", instr_valid, 0);
    rsp_lat  = 1;
    rsp_word = 32'h0050_0093;
    step();
    check("rdw_no_instr2",  instr_valid, 0);
    check("rdw_req_valid",  icache_req_valid, 1);
    check("rdw_req_addr",   icache_req_addr, 32'h0000_1000);

    // Redirect beats instr_ready in PRESENT
    step();
    step();
    check("rdp_instr_valid", instr_valid, 1);
    check("rdp_instr_pc",    instr_pc, 32'h0000_1000);
    check("rdp_instruction", instruction, 32'h0050_0093);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    instr_ready    = 1'b1;
    step();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    check("rdp_dropped",  instr_valid, 0);
    check("rdp_req_addr", icache_req_addr, 32'h0000_2000);

    // Redirect in REQUEST without a handshake, to the top word
    icache_req_ready = 1'b0;
    redirect_valid   = 1'b1;
    redirect_pc      = 32'hFFFF_FFFF;
    step();
    redirect_valid   = 1'b0;
    icache_req_ready = 1'b1;
    check("rdr_req_valid", icache_req_valid, 1);
    check("rdr_req_addr",  icache_req_addr, 32'hFFFF_FFFC);
    fault_addr = 32'hFFFF_FFFC;
    rsp_word   = 32'hDEAD_BEEF;
    step();
    step();
    check("flt_instr_valid", instr_valid, 1);
    check("flt_instr_pc",    instr_pc, 32'hFFFF_FFFC);
    check("flt_instr_fault", instr_fault, 1);
    check("flt_instruction", instruction, 32'hDEAD_BEEF);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("wrap_req_valid", icache_req_valid, 1);
    check("wrap_req_addr",  icache_req_addr, 32'h0000_0000);

    // Redirect together with a request handshake
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    step();
    redirect_valid = 1'b0;
    check("rdh_waiting", icache_req_valid, 0);
    rsp_lat = 3;
    step();
    check("rdh_no_instr",  instr_valid, 0);
    check("rdh_req_valid", icache_req_valid, 1);
    check("rdh_req_addr",  icache_req_addr, 32'h0000_3000);

    // Halt while waiting; the late response must be ignored
    step();
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_halted",    halted, 1);
    check("halt_req_valid", icache_req_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_stays",     halted, 1);
      check("halt_no_req",    icache_req_valid, 0);
      check("halt_no_instr",  instr_valid, 0);
    end

    // Reset from HALT
    rsp_lat = 1;
    rst_n   = 1'b0;
    #1;
    check("hrst_halted",      halted, 0);
    check("hrst_req_valid",   icache_req_valid, 0);
    check("hrst_instr_pc",    instr_pc, 0);
    check("hrst_instruction", instruction, 0);
    step();
    rst_n = 1'b1;
    step();
    check("hrst_req_after",  icache_req_valid, 1);
    check("hrst_addr_after", icache_req_addr, 32'h8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
